gppcu_fpu_arbiter: RTL

Shares one multicycle floating-point unit among NUM_THREAD GPPCU thread lanes so that each lane no longer instantiates its own FPU. Each lane presents a request, opcode and two operands. The arbiter grants one lane at a time in round-robin order, sequences the FPU start/done handshake and returns the result with a one-cycle done pulse to the granted lane. It sits between the thread array's execute stage and a single shared FPU instance.

---
 rtl/gppcu_fpu_arbiter_if.sv | 34 +++
 rtl/gppcu_fpu_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gppcu_fpu_arbiter_if.sv
// Lane-array and shared-FPU signals of the FPU arbiter, bundled for one port.
// The slave modport is the arbiter itself; the master modport is the lanes plus FPU.
// Lane k occupies iOPC[3k+:3], iDA[32k+:32] and iDB[32k+:32].
interface gppcu_fpu_arbiter_if #(
  parameter int NUM_THREAD = 4
);
  logic [NUM_THREAD-1:0]    iREQ;
  logic [3*NUM_THREAD-1:0]  iOPC;
  logic [32*NUM_THREAD-1:0] iDA;
  logic [32*NUM_THREAD-1:0] iDB;
  logic [NUM_THREAD-1:0]    oGRANT;
  logic [NUM_THREAD-1:0]    oDONE;
  logic [31:0]              oRESULT;
  logic                     oBUSY;
  logic                     oTIMEOUT;
  logic                     oFPU_START;
  logic [2:0]               oFPU_N;
  logic [31:0]              oFPU_DA;
  logic [31:0]              oFPU_DB;
  logic                     iFPU_DONE;
  logic [31:0]              iFPU_RESULT;

  modport slave (
    input  iREQ, iOPC, iDA, iDB, iFPU_DONE, iFPU_RESULT,
    output oGRANT, oDONE, oRESULT, oBUSY, oTIMEOUT,
    output oFPU_START, oFPU_N, oFPU_DA, oFPU_DB
  );

  modport master (
    output iREQ, iOPC, iDA, iDB, iFPU_DONE, iFPU_RESULT,
    input  oGRANT, oDONE, oRESULT, oBUSY, oTIMEOUT,
    input  oFPU_START, oFPU_N, oFPU_DA, oFPU_DB
  );
endinterface

// File: rtl/gppcu_fpu_arbiter.sv
// Round-robin arbiter sharing one multicycle FPU among NUM_THREAD lanes.
// Latency: grant 1 cycle after request, oDONE 1 cycle after iFPU_DONE, IDLE 1 cycle later.
// Backpressure: lanes hold iREQ until granted; one operation in flight at a time.
// Optional watchdog in WAIT: define GPPCU_FPU_ARB_TIMEOUT_EN (aborts with quiet NaN).
module gppcu_fpu_arbiter #(
  parameter int NUM_THREAD     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               iACLK,
  input  logic               iRST,
  gppcu_fpu_arbiter_if.slave bus
);

  localparam int            IW        = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(NUM_THREAD - 1);
  localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic [NUM_THREAD-1:0] grant;
  logic [NUM_THREAD-1:0] done;
  logic [31:0]           result;
  logic                  busy;
  logic                  fpu_start;
  logic [2:0]            fpu_n;
  logic [31:0]           fpu_da;
  logic [31:0]           fpu_db;

  logic                  pick_vld;
  logic [IW-1:0]         pick_idx;
  logic [NUM_THREAD-1:0] pick_onehot;
  logic [2:0]            pick_opc;
  logic [31:0]           pick_da;
  logic [31:0]           pick_db;
  int                    scan_lane;

`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog;
  logic        timeout;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin scan: the lowest offset above rr_ptr (with wrap) wins, so scan
  // from the farthest offset down and let the nearest requester overwrite.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = rr_ptr;
    scan_lane = 0;
    for (int i = NUM_THREAD; i >= 1; i--) begin
      scan_lane = int'(rr_ptr) + i;
      if (scan_lane >= NUM_THREAD) begin
        scan_lane = scan_lane - NUM_THREAD;
      end
      if ((bus.iREQ & (NUM_THREAD'(1) << scan_lane)) != '0) begin
        pick_vld = 1'b1;
        pick_idx = IW'(scan_lane);
      end
    end
  end

  // Steer the winning lane's opcode and operands toward the FPU latches.
  always_comb begin
    pick_onehot = NUM_THREAD'(1) << pick_idx;
    pick_opc    = 3'(bus.iOPC >> (3 * int'(pick_idx)));
    pick_da     = 32'(bus.iDA >> (32 * int'(pick_idx)));
    pick_db     = 32'(bus.iDB >> (32 * int'(pick_idx)));
  end

  // Operation sequencer: grant, start pulse, wait for completion, done pulse.
  always_ff @(posedge iACLK) begin
    if (iRST) begin
      state     <= IDLE;
      rr_ptr    <= LAST_LANE;
      gnt_idx   <= '0;
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      fpu_start <= 1'b0;
      fpu_n     <= '0;
      fpu_da    <= '0;
      fpu_db    <= '0;
`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
      wdog      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A completion arriving here belongs to a dropped operation; ignore it.
          if (pick_vld) begin
            gnt_idx   <= pick_idx;
            grant     <= pick_onehot;
            fpu_n     <= pick_opc;
            fpu_da    <= pick_da;
            fpu_db    <= pick_db;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start <= 1'b0;
`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
          wdog      <= '0;
`endif
          state     <= WAIT;
        end
        WAIT: begin
          if (bus.iFPU_DONE) begin
            result <= bus.iFPU_RESULT;
            done   <= grant;
            state  <= RESP;
`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
          end else if (wdog == WDOG_LAST) begin
            result  <= QNAN;
            done    <= grant;
            timeout <= 1'b1;
            state   <= RESP;
          end else begin
            wdog <= wdog + 16'd1;
`endif
          end
        end
        RESP: begin
          rr_ptr <= gnt_idx;
          grant  <= '0;
          done   <= '0;
          result <= '0;
          busy   <= 1'b0;
`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oGRANT     = grant;
  assign bus.oDONE      = done;
  assign bus.oRESULT    = result;
  assign bus.oBUSY      = busy;
  assign bus.oFPU_START = fpu_start;
  assign bus.oFPU_N     = fpu_n;
  assign bus.oFPU_DA    = fpu_da;
  assign bus.oFPU_DB    = fpu_db;
`ifdef GPPCU_FPU_ARB_TIMEOUT_EN
  assign bus.oTIMEOUT   = timeout;
`else
  assign bus.oTIMEOUT   = 1'b0;
`endif

endmodule
